avg_pool_multi: RTL and testbench



---
 rtl/avg_pool_multi.sv | 129 ++++++++++++
 tb/tb_avg_pool_multi.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/avg_pool_multi.sv
// Multi-channel 2x2 FP16 average pool, one channel per clock through a shared adder bank.
// Define AVGPOOL_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module avg_pool_multi #(
    parameter int D = 16,
    parameter int H = 10,
    parameter int W = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [D*H*W*16-1:0]           apInput,
    output logic [D*(H/2)*(W/2)*16-1:0]   apOutput
);

    localparam int HO     = H / 2;
    localparam int WO     = W / 2;
    localparam int IN_SL  = H * W * 16;
    localparam int OUT_SL = HO * WO * 16;
    localparam int CW     = $clog2(D) + 1;

`ifdef AVGPOOL_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    // Mantissas carry 3 extra bits (guard, round, sticky); subnormal inputs flush to zero.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [14:0]       ka, kb;
        logic [15:0]       x, y;
        logic [13:0]       mx, my, sh, mn;
        logic [4:0]        diff, lz;
        logic [31:0]       wide;
        logic [14:0]       m;
        logic signed [7:0] re;
        logic [11:0]       kept;
        logic              inc;
        logic [15:0]       res;
        ka   = (a[14:10] == 5'd0) ? 15'd0 : a[14:0];
        kb   = (b[14:10] == 5'd0) ? 15'd0 : b[14:0];
        x    = (ka < kb) ? b : a;
        y    = (ka < kb) ? a : b;
        mx   = (x[14:10] == 5'd0) ? 14'd0 : {1'b1, x[9:0], 3'b000};
        my   = (y[14:10] == 5'd0) ? 14'd0 : {1'b1, y[9:0], 3'b000};
        diff = x[14:10] - y[14:10];
        wide = {my, 18'd0} >> diff;
        sh   = {wide[31:19], |wide[18:0]};
        if (x[15] == y[15]) m = {1'b0, mx} + {1'b0, sh};
        else                m = {1'b0, mx} - {1'b0, sh};
        re = $signed({3'b000, x[14:10]});
        lz = 5'd0;
        for (int i = 0; i < 14; i++) begin
            if (m[i]) lz = 5'(13 - i);
        end
        if (m[14]) begin
            mn = {m[14:2], m[1] | m[0]};
            re = re + 8'sd1;
        end else begin
            mn = m[13:0] << lz;
            re = re - $signed({3'b000, lz});
        end
        inc  = RNE_EN & mn[2] & (mn[1] | mn[0] | mn[3]);
        kept = {1'b0, mn[13:3]} + {11'd0, inc};
        if (kept[11]) begin
            kept = {1'b0, kept[11:1]};
            re   = re + 8'sd1;
        end
        if (m == 15'd0 || re <= 8'sd0) res = 16'h0000;
        else if (re >= 8'sd31)         res = {x[15], 15'h7BFF};
        else                           res = {x[15], re[4:0], kept[9:0]};
        return res;
    endfunction

    // Divide by 4 is an exponent decrement; anything that would reach exponent 0 flushes.
    function automatic logic [15:0] fp16_div4(input logic [15:0] s);
        if (s[14:10] <= 5'd2) return 16'h0000;
        return {s[15], s[14:10] - 5'd2, s[9:0]};
    endfunction

    logic [CW-1:0]       ch_q, ch_d;
    logic [D*OUT_SL-1:0] out_q, out_d;
    logic [IN_SL-1:0]    in_sl;
    logic [OUT_SL-1:0]   pool_sl;
    logic                busy;

    assign busy = (ch_q < CW'(D));

    always_comb begin
        in_sl = '0;
        for (int d = 0; d < D; d++) begin
            if (ch_q == CW'(d)) in_sl = apInput[d*IN_SL +: IN_SL];
        end
    end

    for (genvar r = 0; r < HO; r++) begin : g_row
        for (genvar c = 0; c < WO; c++) begin : g_col
            logic [15:0] s0, s1, sum;
            assign s0  = fp16_add(in_sl[((2*r)*W + 2*c)*16 +: 16],
                                  in_sl[((2*r)*W + 2*c + 1)*16 +: 16]);
            assign s1  = fp16_add(in_sl[((2*r+1)*W + 2*c)*16 +: 16],
                                  in_sl[((2*r+1)*W + 2*c + 1)*16 +: 16]);
            assign sum = fp16_add(s0, s1);
            assign pool_sl[(r*WO + c)*16 +: 16] = fp16_div4(sum);
        end
    end

    always_comb begin
        ch_d  = ch_q;
        out_d = out_q;
        if (busy) begin
            ch_d = ch_q + CW'(1);
            for (int d = 0; d < D; d++) begin
                if (ch_q == CW'(d)) out_d[d*OUT_SL +: OUT_SL] = pool_sl;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q  <= '0;
            out_q <= '0;
        end else begin
            ch_q  <= ch_d;
            out_q <= out_d;
        end
    end

    assign apOutput = out_q;

endmodule

// File: tb/tb_avg_pool_multi.sv
// Directed bench for avg_pool_multi: hand-computed FP16 pooling results and timing checks.
module tb_avg_pool_multi;
  localparam int D = 16;
  localparam int H = 10;
  localparam int W = 10;
  localparam int HO = H / 2;
  localparam int WO = W / 2;
  localparam int OUT_SL = HO * WO * 16;

  logic clk;
  logic reset;
  logic [D*H*W*16-1:0] apInput;
  logic [D*HO*WO*16-1:0] apOutput;

  logic [D*HO*WO*16-1:0] exp_t;
  logic [OUT_SL-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] enc [16] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600,
                            16'h4700, 16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00,
                            16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};

  avg_pool_multi #(.D(D), .H(H), .W(W)) dut (
    .clk(clk),
    .reset(reset),
    .apInput(apInput),
    .apOutput(apOutput)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_chan(input int d, input logic [15:0] v);
    for (int i = 0; i < H * W; i++) apInput[(d*H*W + i)*16 +: 16] = v;
  endtask

  task automatic set_win(input int d, input int r, input int c, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] e, input logic [15:0] f);
    apInput[((d*H + 2*r)*W + 2*c)*16 +: 16]       = a;
    apInput[((d*H + 2*r)*W + 2*c + 1)*16 +: 16]   = b;
    apInput[((d*H + 2*r + 1)*W + 2*c)*16 +: 16]   = e;
    apInput[((d*H + 2*r + 1)*W + 2*c + 1)*16 +: 16] = f;
  endtask

  task automatic exp_chan(input int d, input logic [15:0] v);
    for (int i = 0; i < HO * WO; i++) exp_t[(d*HO*WO + i)*16 +: 16] = v;
  endtask

  task automatic exp_el(input int d, input int r, input int c, input logic [15:0] v);
    exp_t[((d*HO + r)*WO + c)*16 +: 16] = v;
  endtask

  // scoreboard: one comparison per channel slice
  task automatic check_tensor(input string tag);
    logic [OUT_SL-1:0] e, obs;
    for (int d = 0; d < D; d++) exp_q.push_back(exp_t[d*OUT_SL +: OUT_SL]);
    for (int d = 0; d < D; d++) begin
      e = exp_q.pop_front();
      obs = apOutput[d*OUT_SL +: OUT_SL];
      n_tests++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s ch%0d observed=%h expected=%h", tag, d, obs, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    apInput = '0;
    exp_t = '0;
    #1;
    check_tensor("reset_state");

    // all ones
    for (int d = 0; d < D; d++) fill_chan(d, 16'h3C00);
    @(negedge clk);
    pulse_reset();
    tick(17);
    for (int d = 0; d < D; d++) exp_chan(d, 16'h3C00);
    check_tensor("all_one");

    // directed windows, one per channel, everything else zero
    apInput = '0;
    set_win(0, 0, 0, 16'h3C00, 16'hBC00, 16'h3C00, 16'hBC00);
    set_win(1, 1, 1, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    set_win(2, 0, 0, 16'h0400, 16'h0400, 16'h0400, 16'h0400);
    set_win(3, 2, 1, 16'h3C00, 16'h4000, 16'h4200, 16'h4400);
    set_win(4, 4, 4, 16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF);
    set_win(5, 0, 0, 16'h3C01, 16'h3C00, 16'h0000, 16'h0000);
    set_win(6, 1, 2, 16'h3C00, 16'h9200, 16'h0000, 16'h0000);
    set_win(7, 3, 3, 16'h3C00, 16'h1200, 16'h0000, 16'h0000);
    set_win(8, 0, 0, 16'hC000, 16'hC000, 16'hC000, 16'hC000);
    set_win(9, 2, 3, 16'h0400, 16'h0000, 16'h0000, 16'h0000);
    set_win(10, 1, 1, 16'h0C00, 16'h0000, 16'h0000, 16'h0000);
    pulse_reset();
    #1;
    exp_t = '0;
    check_tensor("reset_clears");
    tick(17);
    exp_el(2, 0, 0, 16'h0400);
    exp_el(3, 2, 1, 16'h4100);
    exp_el(4, 4, 4, 16'h73FF);
    exp_el(5, 0, 0, 16'h3800);
    exp_el(6, 1, 2, 16'h33FE);
    exp_el(7, 3, 3, 16'h3400);
    exp_el(8, 0, 0, 16'hC000);
    exp_el(10, 1, 1, 16'h0400);
    check_tensor("windows");

    // channel k = k+1, partial then complete
    for (int d = 0; d < D; d++) fill_chan(d, enc[d]);
    pulse_reset();
    tick(8);
    exp_t = '0;
    for (int d = 0; d < 8; d++) exp_chan(d, enc[d]);
    check_tensor("ramp_8");
    tick(9);
    for (int d = 0; d < D; d++) exp_chan(d, enc[d]);
    check_tensor("ramp_full");

    // input changes after completion are ignored
    for (int i = 0; i < D * H * W; i++) apInput[i*16 +: 16] = 16'($urandom_range(0, 16'h7BFF));
    tick(3);
    check_tensor("done_hold");

    // mid-run reset with a new input
    for (int d = 0; d < D; d++) fill_chan(d, 16'h3C00);
    pulse_reset();
    tick(5);
    exp_t = '0;
    for (int d = 0; d < 5; d++) exp_chan(d, 16'h3C00);
    check_tensor("midrun_5");
    reset = 1'b1;
    for (int d = 0; d < D; d++) fill_chan(d, 16'h4000);
    #1;
    exp_t = '0;
    check_tensor("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    tick(16);
    for (int d = 0; d < D; d++) exp_chan(d, 16'h4000);
    check_tensor("midrun_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
